// File: rtl/free_tag_pool.sv
`default_nettype none
// ============================================================================
// Module      : free_tag_pool
// Description : Physical-tag free list for the Rename stage. Holds every
//               unallocated physical tag in a circular FIFO, hands out up to
//               two tags per cycle to Rename, and absorbs up to two tags per
//               cycle retired by the reorder buffer. Tag p0 is never stored.
//
// Ports
//   clk          in   1          clock, all state updates on posedge
//   rst_n        in   1          asynchronous active-low reset
//   alloc_num    in   2          tags requested this cycle (0, 1 or 2)
//   freed_tag_1  in   TAG_WIDTH  first retired tag, 0 = none
//   freed_tag_2  in   TAG_WIDTH  second retired tag, 0 = none
//   alloc_grant  out  1          request satisfied this cycle (all-or-nothing)
//   alloc_tag_1  out  TAG_WIDTH  first granted tag, 0 when not granted
//   alloc_tag_2  out  TAG_WIDTH  second granted tag, 0 unless two granted
//   free_count   out  TAG_WIDTH+1 registered number of tags in the pool
//
// Revision    : 1.0  initial release
// ============================================================================
module free_tag_pool #(
  parameter int unsigned NUM_TAGS      = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned TAG_WIDTH     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           alloc_num,
  input  logic [TAG_WIDTH-1:0] freed_tag_1,
  input  logic [TAG_WIDTH-1:0] freed_tag_2,
  output logic                 alloc_grant,
  output logic [TAG_WIDTH-1:0] alloc_tag_1,
  output logic [TAG_WIDTH-1:0] alloc_tag_2,
  output logic [TAG_WIDTH:0]   free_count
);

  localparam int unsigned c_cnt_w      = TAG_WIDTH + 1;
  localparam int unsigned c_reset_free = NUM_TAGS - NUM_ARCH_REGS;

  // Tags NUM_ARCH_REGS..NUM_TAGS-1 start out free; the architectural
  // mappings p0..p(NUM_ARCH_REGS-1) are live at reset.
  localparam logic [NUM_TAGS-1:0] c_in_pool_rst = {NUM_TAGS{1'b1}} << NUM_ARCH_REGS;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TAG_WIDTH-1:0] r_fifo [NUM_TAGS];
  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [c_cnt_w-1:0]   r_count;
  logic [NUM_TAGS-1:0]  r_in_pool;

  // --------------------------------------------------------------------------
  // Allocation side (combinational from registered state)
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]   w_req;
  logic                 w_grant;
  logic [TAG_WIDTH-1:0] w_head_plus1;
  logic [TAG_WIDTH-1:0] w_head_tag_1;
  logic [TAG_WIDTH-1:0] w_head_tag_2;
  logic [1:0]           w_pop_num;

  assign w_req        = c_cnt_w'(alloc_num);
  // Decision looks only at the registered count: a tag freed this cycle is
  // not visible to the grant until the next cycle.
  assign w_grant      = (w_req <= r_count);
  assign w_head_plus1 = r_head + TAG_WIDTH'(1);
  assign w_head_tag_1 = r_fifo[r_head];
  assign w_head_tag_2 = r_fifo[w_head_plus1];
  assign w_pop_num    = w_grant ? alloc_num : 2'd0;

  assign alloc_grant  = w_grant;
  assign alloc_tag_1  = (w_grant && (alloc_num != 2'd0)) ? w_head_tag_1 : '0;
  assign alloc_tag_2  = (w_grant && (alloc_num == 2'd2)) ? w_head_tag_2 : '0;
  assign free_count   = r_count;

  // --------------------------------------------------------------------------
  // Free side
  // --------------------------------------------------------------------------
  logic                 w_push_1;
  logic                 w_push_2;
  logic [1:0]           w_push_num;
  logic [TAG_WIDTH-1:0] w_wr_addr_1;
  logic [TAG_WIDTH-1:0] w_wr_addr_2;
  logic [c_cnt_w-1:0]   w_count_next;

  assign w_push_1    = (freed_tag_1 != '0);
  assign w_push_2    = (freed_tag_2 != '0);
  assign w_push_num  = {1'b0, w_push_1} + {1'b0, w_push_2};
  // Compaction: the second tag lands at the tail itself when the first
  // slot carries no tag.
  assign w_wr_addr_1 = r_tail;
  assign w_wr_addr_2 = r_tail + TAG_WIDTH'(w_push_1);

  assign w_count_next = r_count - c_cnt_w'(w_pop_num) + c_cnt_w'(w_push_num);

  // --------------------------------------------------------------------------
  // FIFO storage: one register per entry with its own write decode
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_entry
    localparam logic [TAG_WIDTH-1:0] c_init =
      (i < c_reset_free) ? TAG_WIDTH'(NUM_ARCH_REGS + i) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fifo[i] <= c_init;
      end else if (w_push_1 && (w_wr_addr_1 == TAG_WIDTH'(i))) begin
        r_fifo[i] <= freed_tag_1;
      end else if (w_push_2 && (w_wr_addr_2 == TAG_WIDTH'(i))) begin
        r_fifo[i] <= freed_tag_2;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= TAG_WIDTH'(c_reset_free);
      r_count <= c_cnt_w'(c_reset_free);
    end else begin
      r_head  <= r_head + TAG_WIDTH'(w_pop_num);
      r_tail  <= r_tail + TAG_WIDTH'(w_push_num);
      r_count <= w_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Membership bitmap, kept only to catch protocol violations
  // --------------------------------------------------------------------------
  logic [NUM_TAGS-1:0] w_in_pool_next;

  always_comb begin
    w_in_pool_next = r_in_pool;
    // A pushed tag cannot also be popped (it was not in the pool), so the
    // order of clear and set does not matter for legal traffic.
    if (w_pop_num != 2'd0) begin
      w_in_pool_next[w_head_tag_1] = 1'b0;
    end
    if (w_pop_num == 2'd2) begin
      w_in_pool_next[w_head_tag_2] = 1'b0;
    end
    if (w_push_1) begin
      w_in_pool_next[freed_tag_1] = 1'b1;
    end
    if (w_push_2) begin
      w_in_pool_next[freed_tag_2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pool <= c_in_pool_rst;
    end else begin
      r_in_pool <= w_in_pool_next;
    end
  end

`ifndef SYNTHESIS
  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    if (rst_n) begin
      if (alloc_num == 2'd3) begin
        $fatal(1, "free_tag_pool: illegal alloc_num 3");
      end
      if (w_push_1 && r_in_pool[freed_tag_1]) begin
        $fatal(1, "free_tag_pool: double free of tag %0d", freed_tag_1);
      end
      if (w_push_2 && r_in_pool[freed_tag_2]) begin
        $fatal(1, "free_tag_pool: double free of tag %0d", freed_tag_2);
      end
      if (w_push_1 && (freed_tag_1 == freed_tag_2)) begin
        $fatal(1, "free_tag_pool: same tag %0d freed twice in one cycle", freed_tag_1);
      end
      if (w_count_next > c_cnt_w'(NUM_TAGS - 1)) begin
        $fatal(1, "free_tag_pool: count overflow (%0d)", w_count_next);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_tag_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_tag_pool
// Description : Directed bench for free_tag_pool. A queue-based reference of
//               the free list predicts grant, tags and count for every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_free_tag_pool;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alloc_num;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;
  logic       alloc_grant;
  logic [5:0] alloc_tag_1;
  logic [5:0] alloc_tag_2;
  logic [6:0] free_count;

  always #5 clk = ~clk;

  free_tag_pool #(
    .NUM_TAGS      (64),
    .NUM_ARCH_REGS (32),
    .TAG_WIDTH     (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_num   (alloc_num),
    .freed_tag_1 (freed_tag_1),
    .freed_tag_2 (freed_tag_2),
    .alloc_grant (alloc_grant),
    .alloc_tag_1 (alloc_tag_1),
    .alloc_tag_2 (alloc_tag_2),
    .free_count  (free_count)
  );

  typedef struct {
    logic       grant;
    logic [5:0] tag_1;
    logic [5:0] tag_2;
    logic [6:0] cnt;
  } exp_t;

  int   vectors     = 0;
  int   miscompares = 0;
  int   model[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    model.delete();
    for (int t = 32; t < 64; t++) model.push_back(t);
  endtask

  // One cycle: drive at negedge, predict, sample 1ns later, then advance
  // the reference for the coming posedge.
  task automatic step(input logic [1:0] an, input logic [5:0] f1,
                      input logic [5:0] f2, input string name);
    exp_t e;
    exp_t got;
    @(negedge clk);
    alloc_num   = an;
    freed_tag_1 = f1;
    freed_tag_2 = f2;
    e.cnt   = 7'(model.size());
    e.grant = (int'(an) <= model.size());
    e.tag_1 = (e.grant && an >= 2'd1) ? 6'(model[0]) : 6'd0;
    e.tag_2 = (e.grant && an == 2'd2) ? 6'(model[1]) : 6'd0;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({name, ".grant"}, 32'(alloc_grant), 32'(got.grant));
    check({name, ".tag1"},  32'(alloc_tag_1), 32'(got.tag_1));
    check({name, ".tag2"},  32'(alloc_tag_2), 32'(got.tag_2));
    check({name, ".count"}, 32'(free_count),  32'(got.cnt));
    if (got.grant) begin
      for (int k = 0; k < int'(an); k++) void'(model.pop_front());
    end
    if (f1 != 6'd0) model.push_back(int'(f1));
    if (f2 != 6'd0) model.push_back(int'(f2));
  endtask

  initial begin
    rst_n       = 1'b0;
    alloc_num   = 2'd0;
    freed_tag_1 = 6'd0;
    freed_tag_2 = 6'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    step(2'd0, 6'd0, 6'd0, "idle");
    check("rst.count", 32'(free_count), 32);
    check("rst.grant", 32'(alloc_grant), 1);
    check("rst.tag1", 32'(alloc_tag_1), 0);

    // Drain in pairs
    for (int k = 0; k < 16; k++) begin
      step(2'd2, 6'd0, 6'd0, "drain");
      check("drain.pair1", 32'(alloc_tag_1), 32'(32 + 2 * k));
      check("drain.pair2", 32'(alloc_tag_2), 32'(33 + 2 * k));
    end
    step(2'd1, 6'd0, 6'd0, "empty");
    check("empty.count", 32'(free_count), 0);
    check("empty.grant", 32'(alloc_grant), 0);
    check("empty.tag1", 32'(alloc_tag_1), 0);

    // Free and allocate in the same cycle: no bypass
    step(2'd1, 6'd5, 6'd0, "nobypass");
    check("nobypass.grant", 32'(alloc_grant), 0);
    step(2'd1, 6'd0, 6'd0, "reuse");
    check("reuse.tag1", 32'(alloc_tag_1), 5);

    // Refill 34 tags starting at index 33 so the tail wraps 63 -> 0
    step(2'd0, 6'd1, 6'd2, "fill");
    for (int t = 32; t <= 38; t += 2) step(2'd0, 6'(t), 6'(t + 1), "fill");
    for (int t = 43; t <= 61; t += 2) step(2'd0, 6'(t), 6'(t + 1), "fill");
    step(2'd0, 6'd63, 6'd0, "fill");
    step(2'd0, 6'd0, 6'd40, "compact");
    step(2'd0, 6'd41, 6'd42, "fill");
    for (int k = 0; k < 17; k++) begin
      step(2'd2, 6'd0, 6'd0, "wrapdrain");
      if (k == 15) begin
        check("wrap.tag63", 32'(alloc_tag_1), 63);
        check("wrap.tag40", 32'(alloc_tag_2), 40);
      end
    end
    check("wrap.last1", 32'(alloc_tag_1), 41);
    check("wrap.last2", 32'(alloc_tag_2), 42);

    // Alloc 2 + free 2 at count 2
    step(2'd0, 6'd10, 6'd11, "pre");
    step(2'd2, 6'd12, 6'd13, "simul");
    check("simul.grant", 32'(alloc_grant), 1);
    step(2'd1, 6'd0, 6'd0, "after");
    check("after.count", 32'(free_count), 2);
    check("after.head", 32'(alloc_tag_1), 12);
    // No partial grant with one tag left
    step(2'd2, 6'd0, 6'd0, "partial");
    check("partial.grant", 32'(alloc_grant), 0);
    step(2'd1, 6'd0, 6'd0, "last");
    step(2'd0, 6'd0, 6'd0, "drained");

    // Asynchronous reset between edges
    @(negedge clk);
    alloc_num = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(free_count), 32);
    check("arst.grant", 32'(alloc_grant), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(2'd1, 6'd0, 6'd0, "post_rst");
    check("post_rst.tag1", 32'(alloc_tag_1), 32);
    step(2'd0, 6'd0, 6'd0, "post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
